// File: rtl/peak_level_meter_pkg.sv
// Shared types and helpers for the peak level meter: FSM states, level geometry
// and the thermometer encoder feeding the LED bar graph.
package level_meter_pkg;

   localparam int LEVELS  = 8;
   localparam int LEVEL_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      DECAY
   } state_t;

   function automatic logic [LEVELS-1:0] thermo(input logic [LEVEL_W-1:0] level);
      logic [LEVELS-1:0] code;
      code = '0;
      for (int unsigned i = 0; i < LEVELS; i++) begin
         if (i < 32'(level)) code[i] = 1'b1;
      end
      return code;
   endfunction

endpackage

// File: rtl/peak_level_meter_if.sv
// Sample-in / level-out bus of the peak level meter.
// Clip signals exist only when CLIP_DETECT_EN is defined.
interface peak_level_meter_if #(
   parameter int SAMPLE_W = 12
);
   import level_meter_pkg::*;

   logic                sample_valid;
   logic [SAMPLE_W-1:0] sample;
   logic [LEVELS-1:0]   level_code;
   logic [LEVEL_W-1:0]  level_idx;
`ifdef CLIP_DETECT_EN
   logic                clip;
   logic                clip_clr;

   modport master (
      output sample_valid, sample, clip_clr,
      input  level_code, level_idx, clip
   );
   modport slave (
      input  sample_valid, sample, clip_clr,
      output level_code, level_idx, clip
   );
`else
   modport master (
      output sample_valid, sample,
      input  level_code, level_idx
   );
   modport slave (
      input  sample_valid, sample,
      output level_code, level_idx
   );
`endif

endinterface

// File: rtl/peak_level_meter_tick_prescaler.sv
// Free-running divider producing a one-cycle decay tick every TICK_DIV clocks.
module tick_prescaler #(
   parameter int TICK_DIV = 50000
) (
   input  logic clock,
   input  logic resetn,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)                         cnt <= '0;
      else if (cnt == CNT_W'(TICK_DIV - 1)) cnt <= '0;
      else                                 cnt <= cnt + CNT_W'(1);
   end

   assign tick = (cnt == CNT_W'(TICK_DIV - 1));

endmodule

// File: rtl/peak_level_meter.sv
// VU-style peak meter: sample magnitude -> level 0..8, peak hold then stepped decay.
// Optional sticky clip flag is built when CLIP_DETECT_EN is defined.
module peak_level_meter
   import level_meter_pkg::*;
#(
   parameter int SAMPLE_W    = 12,
   parameter int TICK_DIV    = 50000,
   parameter int HOLD_TICKS  = 500,
   parameter int DECAY_TICKS = 20
) (
   input logic               clock,
   input logic               resetn,
   peak_level_meter_if.slave bus
);

   localparam int MAG_W  = SAMPLE_W - 1;
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam int DEC_W  = $clog2(DECAY_TICKS + 1);

   logic                tick;
   logic [SAMPLE_W-1:0] neg;
   logic [MAG_W-1:0]    mag;
   logic [LEVEL_W-1:0]  lvl_d;
   logic [LEVEL_W-1:0]  lvl1;
   logic                v1;
   logic                capture;

   state_t              state_q, state_nx;
   logic [LEVEL_W-1:0]  peak_q, peak_nx;
   logic [HOLD_W-1:0]   hold_q, hold_nx;
   logic [DEC_W-1:0]    dec_q, dec_nx;
   logic [LEVELS-1:0]   code_q, code_nx;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clock  (clock),
      .resetn (resetn),
      .tick   (tick)
   );

   // Stage 1: magnitude (most-negative saturates) quantised on its top three bits
   always_comb begin
      neg = SAMPLE_W'(0) - bus.sample;
      if (!bus.sample[SAMPLE_W-1])          mag = bus.sample[MAG_W-1:0];
      else if (bus.sample[MAG_W-1:0] == '0) mag = '1;
      else                                  mag = neg[MAG_W-1:0];
      lvl_d = (mag == '0) ? '0 : {1'b0, mag[MAG_W-1 -: 3]} + LEVEL_W'(1);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         v1   <= 1'b0;
         lvl1 <= '0;
      end else begin
         v1   <= bus.sample_valid;
         lvl1 <= bus.sample_valid ? lvl_d : '0;
      end
   end

`ifdef CLIP_DETECT_EN
   logic full_scale;
   logic clip_q;

   assign full_scale = bus.sample_valid &&
                       (bus.sample[MAG_W-1:0] == {MAG_W{~bus.sample[SAMPLE_W-1]}});

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)           clip_q <= 1'b0;
      else if (full_scale)   clip_q <= 1'b1;
      else if (bus.clip_clr) clip_q <= 1'b0;
   end

   assign bus.clip = clip_q;
`endif

   assign capture = v1 && (lvl1 != '0) && (lvl1 >= peak_q);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         peak_q  <= '0;
         hold_q  <= '0;
         dec_q   <= '0;
         code_q  <= '0;
      end else begin
         state_q <= state_nx;
         peak_q  <= peak_nx;
         hold_q  <= hold_nx;
         dec_q   <= dec_nx;
         code_q  <= code_nx;
      end
   end

   // A capture swallows a coincident tick; the prescaler itself keeps running
   always_comb begin
      state_nx = state_q;
      peak_nx  = peak_q;
      hold_nx  = hold_q;
      dec_nx   = dec_q;
      if (capture) begin
         state_nx = HOLD;
         peak_nx  = lvl1;
         hold_nx  = HOLD_W'(HOLD_TICKS);
      end else if (tick) begin
         case (state_q)
            IDLE: state_nx = IDLE;
            HOLD: begin
               if (hold_q == HOLD_W'(1)) begin
                  state_nx = DECAY;
                  hold_nx  = '0;
                  dec_nx   = DEC_W'(DECAY_TICKS);
               end else begin
                  hold_nx = hold_q - HOLD_W'(1);
               end
            end
            DECAY: begin
               if (dec_q == DEC_W'(1)) begin
                  peak_nx = peak_q - LEVEL_W'(1);
                  dec_nx  = DEC_W'(DECAY_TICKS);
                  if (peak_q == LEVEL_W'(1)) state_nx = IDLE;
               end else begin
                  dec_nx = dec_q - DEC_W'(1);
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      code_nx = thermo(peak_nx);
   end

   assign bus.level_code = code_q;
   assign bus.level_idx  = peak_q;

endmodule

// File: tb/tb_peak_level_meter.sv
// Directed bench for peak_level_meter (SAMPLE_W=12, TICK_DIV=4, HOLD_TICKS=2, DECAY_TICKS=1).
// Decay ticks land on edges where the post-reset edge count is a multiple of 4.
module tb_peak_level_meter;

   logic        clock;
   logic        resetn;
   int unsigned cyc;
   int          checks;
   int          errors;

   peak_level_meter_if #(.SAMPLE_W(12)) bus ();

   peak_level_meter #(
      .SAMPLE_W    (12),
      .TICK_DIV    (4),
      .HOLD_TICKS  (2),
      .DECAY_TICKS (1)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock or negedge resetn) begin
      if (!resetn) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_level(input string tag, input logic [7:0] code, input logic [3:0] idx);
      check({tag, " code"}, 32'(bus.level_code), 32'(code));
      check({tag, " idx"}, 32'(bus.level_idx), 32'(idx));
   endtask

   task automatic apply_reset();
      @(negedge clock);
      bus.sample_valid = 1'b0;
`ifdef CLIP_DETECT_EN
      bus.clip_clr = 1'b0;
`endif
      #2 resetn = 1'b0;
      @(negedge clock);
      resetn = 1'b1;
   endtask

   // Called on a negedge: sample is taken on the next posedge
   task automatic drive(input logic [11:0] val);
      bus.sample_valid = 1'b1;
      bus.sample       = val;
      @(negedge clock);
      bus.sample_valid = 1'b0;
   endtask

   task automatic wait_to(input int unsigned target);
      while (cyc < target) @(negedge clock);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete in time");
      $fatal(1);
   end

   initial begin
      logic [7:0] full;
      full             = 8'hFF;
      checks           = 0;
      errors           = 0;
      resetn           = 1'b1;
      bus.sample_valid = 1'b0;
      bus.sample       = '0;
`ifdef CLIP_DETECT_EN
      bus.clip_clr     = 1'b0;
`endif
      #1 resetn = 1'b0;
      #2 check_level("reset", 8'h00, 4'd0);
      @(negedge clock);
      resetn = 1'b1;

      // full scale: two-edge latency, then hold 2 ticks and decay one level per tick
      drive(12'h7FF);
      check_level("latency", 8'h00, 4'd0);
      @(negedge clock);
      check_level("full_scale", 8'hFF, 4'd8);
      wait_to(7);
      check_level("hold_end", 8'hFF, 4'd8);
      for (int k = 1; k <= 8; k++) begin
         wait_to(32'(8 + 4 * k - 1));
         check_level("decay_pre", full >> (k - 1), 4'(8 - k + 1));
         wait_to(32'(8 + 4 * k));
         check_level("decay_step", full >> k, 4'(8 - k));
      end
      wait_to(46);
      check_level("idle_stable", 8'h00, 4'd0);

      // quantisation
      apply_reset();
      drive(12'hE00);
      @(negedge clock);
      check_level("neg512", 8'h07, 4'd3);
      drive(12'h001);
      @(negedge clock);
      check_level("lower_ignored", 8'h07, 4'd3);
      apply_reset();
      drive(12'h001);
      @(negedge clock);
      check_level("lsb", 8'h01, 4'd1);
      apply_reset();
      drive(12'h000);
      @(negedge clock);
      check_level("zero", 8'h00, 4'd0);
      repeat (6) @(negedge clock);
      check_level("zero_stays", 8'h00, 4'd0);

      // re-arm in DECAY, lower ignored, capture coincident with a tick
      apply_reset();
      drive(12'h200);
      wait_to(8);
      drive(12'h200);
      wait_to(12);
      check_level("rearm_decay", 8'h07, 4'd3);
      drive(12'h100);
      wait_to(14);
      check_level("lvl2_ignored", 8'h07, 4'd3);
      wait_to(18);
      drive(12'h200);
      wait_to(20);
      check_level("coincident", 8'h07, 4'd3);
      wait_to(31);
      check_level("coincident_hold", 8'h07, 4'd3);
      wait_to(32);
      check_level("coincident_decay", 8'h03, 4'd2);

      // async reset during HOLD with a sample in flight
      apply_reset();
      drive(12'h7FF);
      wait_to(3);
      bus.sample_valid = 1'b1;
      bus.sample       = 12'h7FF;
      @(posedge clock);
      #1 bus.sample_valid = 1'b0;
      #1 resetn = 1'b0;
      #1 check_level("async_reset", 8'h00, 4'd0);
      @(negedge clock);
      resetn = 1'b1;
      repeat (3) @(negedge clock);
      check_level("inflight_drop", 8'h00, 4'd0);

`ifdef CLIP_DETECT_EN
      apply_reset();
      check("clip_reset", 32'(bus.clip), 32'd0);
      drive(12'h800);
      check("clip_set", 32'(bus.clip), 32'd1);
      @(negedge clock);
      check_level("most_negative", 8'hFF, 4'd8);
      bus.sample_valid = 1'b1;
      bus.sample       = 12'h7FF;
      bus.clip_clr     = 1'b1;
      @(negedge clock);
      bus.sample_valid = 1'b0;
      bus.clip_clr     = 1'b0;
      check("clip_set_wins", 32'(bus.clip), 32'd1);
      bus.clip_clr = 1'b1;
      @(negedge clock);
      bus.clip_clr = 1'b0;
      check("clip_clear", 32'(bus.clip), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
